drop_ctrl: RTL and testbench

DROP_CTRL -- requirements
Module: drop_ctrl

---
 rtl/drop_ctrl.sv | 164 ++++++++++++++++
 tb/tb_drop_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/drop_ctrl.sv
// rtl/drop_ctrl.sv - gravity, lock-delay and hard-drop sequencer for the falling piece
module drop_ctrl #(
  parameter int GRAVITY_CYCLES = 100_000_000,
  parameter int SOFT_CYCLES    = 10_000_000,
  parameter int LOCK_CYCLES    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn,
  input  logic       can_fall,
  input  logic [4:0] shadow_dy,
  input  logic       soft_drop,
  input  logic       hard_drop,
  input  logic       pause,
  input  logic       lock_ack,
  output logic       move_down,
  output logic [4:0] drop_rows,
  output logic       lock_req,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FALL = 2'd1,
    S_LAND = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  localparam logic [26:0] GRAV_M1 = 27'(GRAVITY_CYCLES - 1);
  localparam logic [26:0] SOFT_M1 = 27'(SOFT_CYCLES - 1);
  localparam logic [26:0] LOCK_M1 = 27'(LOCK_CYCLES - 1);
  localparam logic [26:0] CNT_MAX = '1;

  state_t      state_q, state_d;
  logic [26:0] grav_q, grav_d;
  logic [26:0] lock_q, lock_d;
  logic        pend_q, pend_d;
  logic [1:0]  settle_q, settle_d;
  logic        move_q, move_d;
  logic [4:0]  rows_q, rows_d;
  logic        lreq_q, lreq_d;
  logic        hd_prev_q;

  logic        hd_edge;
  logic        hd_now;
  logic        in_settle;
  logic [26:0] th_m1;

  function automatic logic [26:0] sat_inc(input logic [26:0] v);
    return (v == CNT_MAX) ? v : v + 27'd1;
  endfunction

  assign hd_edge   = hard_drop & ~hd_prev_q;
  assign hd_now    = pend_q | hd_edge;
  // The ghost row count lags a move by one cycle, so the pulse cycle and the one after are skipped.
  assign in_settle = (settle_q != 2'd0);
  assign th_m1     = soft_drop ? SOFT_M1 : GRAV_M1;

  always_comb begin
    state_d  = state_q;
    grav_d   = grav_q;
    lock_d   = lock_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    move_d   = 1'b0;
    rows_d   = 5'd0;
    lreq_d   = lreq_q;

    if (!pause) begin
      if (in_settle) settle_d = settle_q - 2'd1;
      if (hd_edge)   pend_d   = 1'b1;

      case (state_q)
        S_IDLE: begin
          if (spawn) begin
            state_d = S_FALL;
            grav_d  = 27'd0;
            lock_d  = 27'd0;
          end
        end

        S_FALL, S_LAND: begin
          if (!in_settle) begin
            if (hd_now) begin
              // Hard drop wins over gravity and lock-delay expiry.
              if (shadow_dy != 5'd0) begin
                move_d = 1'b1;
                rows_d = shadow_dy;
              end
              state_d = S_LOCK;
              pend_d  = 1'b0;
            end else if (state_q == S_FALL) begin
              if (grav_q >= th_m1) begin
                grav_d = 27'd0;
                if (can_fall) begin
                  move_d   = 1'b1;
                  rows_d   = 5'd1;
                  settle_d = 2'd2;
                end else begin
                  state_d = S_LAND;
                  lock_d  = 27'd0;
                end
              end else begin
                grav_d = sat_inc(grav_q);
              end
            end else begin
              if (can_fall) begin
                state_d = S_FALL;
                grav_d  = 27'd0;
                lock_d  = 27'd0;
              end else if (lock_q >= LOCK_M1) begin
                state_d = S_LOCK;
              end else begin
                lock_d = sat_inc(lock_q);
              end
            end
          end
        end

        S_LOCK: begin
          pend_d = 1'b0;
          if (lock_ack) begin
            state_d = S_IDLE;
            lreq_d  = 1'b0;
          end else begin
            lreq_d = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grav_q    <= 27'd0;
      lock_q    <= 27'd0;
      pend_q    <= 1'b0;
      settle_q  <= 2'd0;
      move_q    <= 1'b0;
      rows_q    <= 5'd0;
      lreq_q    <= 1'b0;
      hd_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grav_q    <= grav_d;
      lock_q    <= lock_d;
      pend_q    <= pend_d;
      settle_q  <= settle_d;
      move_q    <= move_d;
      rows_q    <= rows_d;
      lreq_q    <= lreq_d;
      hd_prev_q <= hard_drop;
    end
  end

  assign move_down = move_q;
  assign drop_rows = rows_q;
  assign lock_req  = lreq_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_drop_ctrl.sv
// tb/tb_drop_ctrl.sv - directed and randomized checks of drop_ctrl against a behavioural model
module tb_drop_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       spawn;
  logic       can_fall;
  logic [4:0] shadow_dy;
  logic       soft_drop;
  logic       hard_drop;
  logic       pause;
  logic       lock_ack;
  logic       move_down;
  logic [4:0] drop_rows;
  logic       lock_req;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  drop_ctrl #(.GRAVITY_CYCLES(4), .SOFT_CYCLES(2), .LOCK_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .spawn(spawn), .can_fall(can_fall), .shadow_dy(shadow_dy),
    .soft_drop(soft_drop), .hard_drop(hard_drop), .pause(pause), .lock_ack(lock_ack),
    .move_down(move_down), .drop_rows(drop_rows), .lock_req(lock_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase plus plain integer counters.
  localparam int P_IDLE = 0, P_FALL = 1, P_LAND = 2, P_LOCK = 3;
  int m_phase, m_grav, m_lock, m_settle, m_md, m_rows, m_lreq;
  bit m_pend, m_prev;

  task automatic model_step();
    bit edge_seen, skip;
    int th;
    int nmd, nrows;
    nmd = 0;
    nrows = 0;
    if (rst) begin
      m_phase = P_IDLE; m_grav = 0; m_lock = 0; m_settle = 0;
      m_pend = 0; m_prev = 0; m_md = 0; m_rows = 0; m_lreq = 0;
      return;
    end
    edge_seen = hard_drop && !m_prev;
    m_prev = hard_drop;
    if (!pause) begin
      skip = (m_settle > 0);
      if (skip) m_settle = m_settle - 1;
      if (edge_seen) m_pend = 1;
      if (m_phase == P_IDLE) begin
        if (spawn) begin m_phase = P_FALL; m_grav = 0; m_lock = 0; end
      end else if (m_phase == P_LOCK) begin
        m_pend = 0;
        if (lock_ack) begin m_phase = P_IDLE; m_lreq = 0; end
        else m_lreq = 1;
      end else if (!skip) begin
        if (m_pend) begin
          if (shadow_dy > 0) begin nmd = 1; nrows = shadow_dy; end
          m_phase = P_LOCK;
          m_pend = 0;
        end else if (m_phase == P_FALL) begin
          th = soft_drop ? 2 : 4;
          if (m_grav >= th - 1) begin
            if (can_fall) begin nmd = 1; nrows = 1; m_grav = 0; m_settle = 2; end
            else begin m_phase = P_LAND; m_lock = 0; end
          end else if (m_grav < (1 << 27) - 1) begin
            m_grav = m_grav + 1;
          end
        end else begin
          if (can_fall) begin m_phase = P_FALL; m_grav = 0; m_lock = 0; end
          else if (m_lock >= 2) m_phase = P_LOCK;
          else if (m_lock < (1 << 27) - 1) m_lock = m_lock + 1;
        end
      end
    end
    m_md = nmd;
    m_rows = nrows;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d t=%0t actual=%0d required=%0d", name, cyc, $time, act, exp);
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_move_down", {31'd0, move_down}, m_md);
      check("model_drop_rows", {27'd0, drop_rows}, m_rows);
      check("model_lock_req", {31'd0, lock_req}, m_lreq);
      check("model_busy", {31'd0, busy}, (m_phase != P_IDLE) ? 32'd1 : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; spawn = 0; can_fall = 0; shadow_dy = 0; soft_drop = 0;
    hard_drop = 0; pause = 0; lock_ack = 0;
    step();
    cmp_en = 1'b1;
    step();
    rst = 0;
    step();
    check("reset_move_down", {31'd0, move_down}, 0);
    check("reset_drop_rows", {27'd0, drop_rows}, 0);
    check("reset_lock_req", {31'd0, lock_req}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    cyc = 0;
  endtask

  initial begin
    do_reset();

    // Normal gravity: pulses at 5, 11, 17.
    for (int c = 0; c <= 18; c++) begin
      spawn = (c == 0); can_fall = 1; shadow_dy = 5;
      check("grav_md", {31'd0, move_down}, (c == 5 || c == 11 || c == 17) ? 1 : 0);
      check("grav_rows", {27'd0, drop_rows}, (c == 5 || c == 11 || c == 17) ? 1 : 0);
      check("grav_busy", {31'd0, busy}, (c >= 1) ? 1 : 0);
      step();
    end

    // Land and lock with ack in cycle 12.
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      spawn = (c == 0); can_fall = 0; lock_ack = (c == 12);
      check("lock_req", {31'd0, lock_req}, (c >= 9 && c <= 12) ? 1 : 0);
      check("lock_busy", {31'd0, busy}, (c >= 1 && c <= 12) ? 1 : 0);
      check("lock_md", {31'd0, move_down}, 0);
      step();
    end

    // Hard drop rising in cycle 2 and held.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      spawn = (c == 0); can_fall = 1; shadow_dy = 7; hard_drop = (c >= 2);
      check("hd_md", {31'd0, move_down}, (c == 3) ? 1 : 0);
      check("hd_rows", {27'd0, drop_rows}, (c == 3) ? 7 : 0);
      check("hd_lock_req", {31'd0, lock_req}, (c >= 4) ? 1 : 0);
      step();
    end

    // Ledge slide while lock counter is 1.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      spawn = (c == 0); can_fall = (c >= 6);
      check("ledge_md", {31'd0, move_down}, (c == 11) ? 1 : 0);
      check("ledge_lock_req", {31'd0, lock_req}, 0);
      step();
    end

    // Soft drop: period 4.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      spawn = (c == 0); can_fall = 1; soft_drop = 1;
      check("soft_md", {31'd0, move_down}, (c == 3 || c == 7 || c == 11) ? 1 : 0);
      step();
    end

    // Pause for 10 cycles in the counting region.
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      spawn = (c == 0); can_fall = 1; pause = (c >= 7 && c <= 16);
      check("pause_md", {31'd0, move_down}, (c == 5 || c == 21 || c == 27) ? 1 : 0);
      step();
    end
    pause = 0;

    // Reset while lock_req is high.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      spawn = (c == 0); can_fall = 0;
      check("rstlock_req", {31'd0, lock_req}, (c >= 9) ? 1 : 0);
      if (c == 10) rst = 1;
      step();
    end
    check("rstlock_req_after", {31'd0, lock_req}, 0);
    check("rstlock_busy_after", {31'd0, busy}, 0);
    check("rstlock_md_after", {31'd0, move_down}, 0);
    rst = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      spawn     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) can_fall = ~can_fall;
      shadow_dy = 5'($urandom_range(0, 19));
      if ($urandom_range(0, 9) == 0) soft_drop = ~soft_drop;
      if ($urandom_range(0, 7) == 0) hard_drop = ~hard_drop;
      pause     = ($urandom_range(0, 11) == 0);
      lock_ack  = ($urandom_range(0, 2) == 0);
      step();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
